// File: rtl/csel_pkg.sv
// ============================================================================
// Module   : csel_pkg
// Purpose  : Shared constants and payload types for the carry-select subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package csel_pkg;

  localparam int CSEL_WIDTH         = 32;
  localparam int CSEL_BLOCK         = 8;
  localparam int CSEL_SEL_PER_STAGE = 2;
  localparam int CSEL_NBLK          = CSEL_WIDTH / CSEL_BLOCK;

  // Once a block is resolved its chosen sum lives in sum0; sum1/c0/c1 go stale.
  typedef struct packed {
    logic [CSEL_BLOCK-1:0] sum0;
    logic                  c0;
    logic [CSEL_BLOCK-1:0] sum1;
    logic                  c1;
  } cand_t;

  typedef struct packed {
    cand_t [CSEL_NBLK-1:0] blk;
    logic                  carry;  // carry into the first unresolved block
    logic                  a_msb;
    logic                  b_msb;  // original (uninverted) subtrahend MSB
    logic                  sub;    // 1 = subtract, 0 = add
  } payload_t;

endpackage

`default_nettype wire

// File: rtl/csel_sub_pipe_if.sv
// ============================================================================
// Module   : csel_sub_pipe_if
// Purpose  : Valid/ready operand and result bus; CSEL_SUB_ADD_OP_EN adds op.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csel_sub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
`ifdef CSEL_SUB_ADD_OP_EN
  logic             op;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

`ifdef CSEL_SUB_ADD_OP_EN
  modport slave (
    input  in_valid, a, b, borrow_in, op, out_ready,
    output in_ready, out_valid, diff, borrow_out, overflow
  );
  modport master (
    output in_valid, a, b, borrow_in, op, out_ready,
    input  in_ready, out_valid, diff, borrow_out, overflow
  );
`else
  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, diff, borrow_out, overflow
  );
  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out, overflow
  );
`endif

endinterface

`default_nettype wire

// File: rtl/csel_block.sv
// ============================================================================
// Module   : csel_block
// Purpose  : BLOCK-wide adder producing both carry-in=0 and carry-in=1 results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csel_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] sum0,
  output logic             c0,
  output logic [BLOCK-1:0] sum1,
  output logic             c1
);

  assign {c0, sum0} = {1'b0, a} + {1'b0, b};
  assign {c1, sum1} = {1'b0, a} + {1'b0, b} + (BLOCK+1)'(1);

endmodule

`default_nettype wire

// File: rtl/csel_sub_pipe.sv
// ============================================================================
// Module   : csel_sub_pipe
// Purpose  : Pipelined carry-select a - b - borrow_in (a + ~b + ~borrow_in).
//            Define CSEL_SUB_ADD_OP_EN to add an op input selecting add/sub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csel_sub_pipe
  import csel_pkg::*;
#(
  parameter int WIDTH         = CSEL_WIDTH,
  parameter int BLOCK         = CSEL_BLOCK,
  parameter int SEL_PER_STAGE = CSEL_SEL_PER_STAGE
) (
  input  logic           clk,
  input  logic           rst,
  csel_sub_pipe_if.slave bus
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int R    = NBLK / SEL_PER_STAGE;

  logic                  sub_op;
  logic [WIDTH-1:0]      b_eff;
  cand_t [NBLK-1:0]      cand_in;
  payload_t              in_payload;
  payload_t              stage_d [R+1];
  payload_t              stage_q [R+1];
  logic [R:0]            vld_d;
  logic [R:0]            vld_q;
  logic                  adv;
  payload_t              sel_p;
  logic                  sel_c;
  logic [WIDTH-1:0]      res_diff;

`ifdef CSEL_SUB_ADD_OP_EN
  assign sub_op = bus.op;
`else
  assign sub_op = 1'b1;
`endif

  assign b_eff = sub_op ? ~bus.b : bus.b;

  generate
    for (genvar k = 0; k < NBLK; k++) begin : g_blk
      csel_block #(.BLOCK(BLOCK)) u_blk (
        .a    (bus.a[k*BLOCK +: BLOCK]),
        .b    (b_eff[k*BLOCK +: BLOCK]),
        .sum0 (cand_in[k].sum0),
        .c0   (cand_in[k].c0),
        .sum1 (cand_in[k].sum1),
        .c1   (cand_in[k].c1)
      );
    end
  endgenerate

  always_comb begin
    in_payload       = '0;
    in_payload.blk   = cand_in;
    in_payload.carry = sub_op ? ~bus.borrow_in : bus.borrow_in;
    in_payload.a_msb = bus.a[WIDTH-1];
    in_payload.b_msb = bus.b[WIDTH-1];
    in_payload.sub   = sub_op;
  end

  // Single global enable: the whole pipe shifts or the whole pipe holds.
  assign adv          = ~vld_q[R] | bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    vld_d   = vld_q;
    stage_d = stage_q;
    sel_p   = '0;
    sel_c   = 1'b0;
    if (adv) begin
      vld_d      = {vld_q[R-1:0], bus.in_valid};
      stage_d[0] = in_payload;
      for (int j = 1; j <= R; j++) begin
        sel_p = stage_q[j-1];
        sel_c = sel_p.carry;
        for (int s = 0; s < SEL_PER_STAGE; s++) begin
          if (sel_c) begin
            sel_p.blk[(j-1)*SEL_PER_STAGE+s].sum0 = sel_p.blk[(j-1)*SEL_PER_STAGE+s].sum1;
            sel_c = sel_p.blk[(j-1)*SEL_PER_STAGE+s].c1;
          end else begin
            sel_c = sel_p.blk[(j-1)*SEL_PER_STAGE+s].c0;
          end
        end
        sel_p.carry = sel_c;
        stage_d[j]  = sel_p;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
    stage_q <= stage_d;
  end

  always_comb begin
    res_diff = '0;
    for (int k = 0; k < NBLK; k++) begin
      res_diff[k*BLOCK +: BLOCK] = stage_q[R].blk[k].sum0;
    end
  end

  // Subtract reports borrow (inverted carry); add reports the raw carry.
  assign bus.out_valid  = vld_q[R];
  assign bus.diff       = vld_q[R] ? res_diff : '0;
  assign bus.borrow_out = vld_q[R] & (stage_q[R].sub ^ stage_q[R].carry);
  assign bus.overflow   = vld_q[R]
                        & ~(stage_q[R].a_msb ^ stage_q[R].b_msb ^ stage_q[R].sub)
                        & (res_diff[WIDTH-1] ^ stage_q[R].a_msb);

endmodule

`default_nettype wire

// File: tb/tb_csel_sub_pipe.sv
// ============================================================================
// Module   : tb_csel_sub_pipe
// Purpose  : Directed self-checking bench for csel_sub_pipe (default L = 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csel_sub_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  csel_sub_pipe_if #(.WIDTH(32)) bus ();

  csel_sub_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic run_one(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbin,
                         input logic top, output logic [31:0] d, output logic bo,
                         output logic ov, output int lat);
    bus.a         = ta;
    bus.b         = tb_v;
    bus.borrow_in = tbin;
`ifdef CSEL_SUB_ADD_OP_EN
    bus.op        = top;
`endif
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat++;
    end while (!bus.out_valid && lat < 20);
    d  = bus.diff;
    bo = bus.borrow_out;
    ov = bus.overflow;
`ifdef CSEL_SUB_ADD_OP_EN
    bus.op = 1'b1;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.diff !== 32'h0 || bus.borrow_out !== 1'b0 ||
        bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b diff=%h borrow=%b ovf=%b required 0/0/0/0",
               bus.out_valid, bus.diff, bus.borrow_out, bus.overflow);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic check_vec(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                           input logic tbin, input logic top, input logic [31:0] ed,
                           input logic ebo, input logic eov);
    logic [31:0] d;
    logic        bo;
    logic        ov;
    int          lat;
    run_one(ta, tb_v, tbin, top, d, bo, ov, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required 3", name, lat);
    end
    checks++;
    if (d !== ed) begin
      errors++;
      $display("FAIL %s diff: got %h required %h", name, d, ed);
    end
    checks++;
    if (bo !== ebo) begin
      errors++;
      $display("FAIL %s borrow_out: got %b required %b", name, bo, ebo);
    end
    checks++;
    if (ov !== eov) begin
      errors++;
      $display("FAIL %s overflow: got %b required %b", name, ov, eov);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_subtract();
    check_vec("sub_5_3",      32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b0);
    check_vec("sub_ripple",   32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check_vec("sub_ovf_neg",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    check_vec("sub_3_5",      32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    check_vec("sub_ovf_pos",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
    check_vec("sub_blk_edge", 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    check_vec("sub_mix",      32'h1234_5678, 32'h0123_4567, 1'b1, 1'b1, 32'h1111_1110, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int          sent;
    int          got;
    logic        stalled_prev;
    logic [31:0] d_prev;
    logic        saw_block;
    logic        extra;
    sent = 0;
    got = 0;
    stalled_prev = 1'b0;
    d_prev = '0;
    saw_block = 1'b0;
    extra = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      bus.out_ready = !(cyc >= 4 && cyc < 9);
      if (sent < 6) begin
        bus.in_valid  = 1'b1;
        bus.a         = sent + 10;
        bus.b         = sent;
        bus.borrow_in = 1'b0;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (stalled_prev) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.diff !== d_prev) begin
          errors++;
          $display("FAIL b2b_stall_hold: out_valid=%b diff=%h required 1 and %h",
                   bus.out_valid, bus.diff, d_prev);
        end
      end
      if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.diff !== 32'd10 || bus.borrow_out !== 1'b0 || bus.overflow !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result%0d: diff=%h borrow=%b ovf=%b required 0000000a/0/0",
                   got, bus.diff, bus.borrow_out, bus.overflow);
        end
        got++;
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      d_prev = bus.diff;
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) begin
      #1;
      if (bus.out_valid) extra = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (got !== 6 || sent !== 6) begin
      errors++;
      $display("FAIL b2b_count: sent=%0d received=%0d required 6/6", sent, got);
    end
    checks++;
    if (saw_block !== 1'b1) begin
      errors++;
      $display("FAIL b2b_in_ready_drop: in_ready never low, required low during stall");
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("FAIL b2b_duplicate: extra out_valid after stream, required none");
    end
  endtask

  task automatic test_reset_in_flight();
    logic ghost;
    ghost = 1'b0;
    bus.out_ready = 1'b1;
    bus.borrow_in = 1'b0;
    bus.a = 32'd50;
    bus.b = 32'd1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 32'd60;
    bus.b = 32'd2;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.diff !== 32'h0) begin
      errors++;
      $display("FAIL rst_flush: out_valid=%b diff=%h required 0 and 00000000",
               bus.out_valid, bus.diff);
    end
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) ghost = 1'b1;
    end
    checks++;
    if (ghost !== 1'b0) begin
      errors++;
      $display("FAIL rst_ghost: flushed operation emerged, required none");
    end
    check_vec("post_rst", 32'd100, 32'd1, 1'b0, 1'b1, 32'd99, 1'b0, 1'b0);
  endtask

`ifdef CSEL_SUB_ADD_OP_EN
  task automatic test_add_op();
    check_vec("add_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    check_vec("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    check_vec("add_cin",   32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.borrow_in = 1'b0;
`ifdef CSEL_SUB_ADD_OP_EN
    bus.op = 1'b1;
`endif
    test_reset();
    test_subtract();
    test_back_to_back();
    test_reset_in_flight();
`ifdef CSEL_SUB_ADD_OP_EN
    test_add_op();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
